multicycle_ctrlr: RTL and testbench

FSM controller that sequences the multi-cycle variant of the CPU datapath, where instruction fetch and data access share one memory port with a ready handshake. It decodes the same ISA as the single-cycle controller: lw/sw/jump/branchz/addi/subi/andi/ori, plus rtype with func-encoded ALU and window operations. It drives datapath selects, register/memory/PC/IR write enables and window-change pulses. It also flags a memory timeout and counts retired instructions.

---
 rtl/multicycle_ctrlr.sv | 210 +++++++++++++++++++++
 tb/tb_multicycle_ctrlr.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrlr.sv
// Multi-cycle CPU controller: sequences fetch/decode/execute over a shared memory
// port with a ready handshake, a wait-cycle timeout, and a retired-instruction counter.
module multicycle_ctrlr #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       opcode,
   input  logic [7:0]       func,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             iord,
   output logic             ir_we,
   output logic             pc_we,
   output logic [1:0]       pcsel,
   output logic [1:0]       alusel,
   output logic [2:0]       aluop,
   output logic             datasel,
   output logic             reg_we,
   output logic             changewnd,
   output logic             instr_done,
   output logic             err,
   output logic [CNT_W-1:0] instr_count,
   output logic [3:0]       dbg_state
);

   // Memory handshake: mem_req (with iord/mem_we) is held until the cycle mem_ready
   // is seen high; that cycle completes the request and its side effects fire.
   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DECODE, S_MEM_RD, S_MEM_WR,
      S_JUMP, S_BRZ, S_EXEC_I, S_EXEC_R, S_WND, S_ERR
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [7:0]       r_wait;
   logic [CNT_W-1:0] r_instr_count;
   logic             w_mem_state;
   logic             w_timeout;

   assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
   // The cycle whose miss would bring the count to TIMEOUT is the last one allowed.
   assign w_timeout   = w_mem_state && !mem_ready && (({1'b0, r_wait} + 9'd1) >= 9'(TIMEOUT));

   assign instr_count = r_instr_count;
   assign dbg_state   = r_state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_wait        <= 8'd0;
         r_instr_count <= '0;
      end else begin
         r_state <= w_next;
         if (w_next != r_state)
            r_wait <= 8'd0;
         else if (w_mem_state && !mem_ready)
            r_wait <= r_wait + 8'd1;
         if (instr_done)
            r_instr_count <= r_instr_count + 1'b1;
      end
   end

   always_comb begin
      w_next     = r_state;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pcsel      = 2'd0;
      alusel     = 2'd0;
      aluop      = 3'd0;
      datasel    = 1'b0;
      reg_we     = 1'b0;
      changewnd  = 1'b0;
      instr_done = 1'b0;
      err        = 1'b0;

      case (r_state)
         S_IDLE: w_next = S_FETCH;

         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_we  = 1'b1;
               pc_we  = 1'b1;
               w_next = S_DECODE;
            end else if (w_timeout) begin
               w_next = S_ERR;
            end
         end

         S_DECODE: begin
            case (opcode)
               4'b0000: w_next = S_MEM_RD;
               4'b0001: w_next = S_MEM_WR;
               4'b0010: w_next = S_JUMP;
               4'b0100: w_next = S_BRZ;
               4'b1100, 4'b1101, 4'b1110, 4'b1111: w_next = S_EXEC_I;
               4'b1000: w_next = func[7] ? S_WND : S_EXEC_R;
               default: begin
                  instr_done = 1'b1;
                  w_next     = S_FETCH;
               end
            endcase
         end

         S_MEM_RD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            if (mem_ready) begin
               datasel    = 1'b1;
               reg_we     = 1'b1;
               instr_done = 1'b1;
               w_next     = S_FETCH;
            end else if (w_timeout) begin
               w_next = S_ERR;
            end
         end

         S_MEM_WR: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            iord    = 1'b1;
            if (mem_ready) begin
               instr_done = 1'b1;
               w_next     = S_FETCH;
            end else if (w_timeout) begin
               w_next = S_ERR;
            end
         end

         S_JUMP: begin
            pc_we      = 1'b1;
            pcsel      = 2'd2;
            instr_done = 1'b1;
            w_next     = S_FETCH;
         end

         S_BRZ: begin
            aluop      = 3'd4;
            pc_we      = zero;
            pcsel      = zero ? 2'd1 : 2'd0;
            instr_done = 1'b1;
            w_next     = S_FETCH;
         end

         S_EXEC_I: begin
            reg_we     = 1'b1;
            alusel     = 2'd2;
            instr_done = 1'b1;
            w_next     = S_FETCH;
            case (opcode[1:0])
               2'b00:   aluop = 3'd3;
               2'b01:   aluop = 3'd5;
               2'b10:   aluop = 3'd0;
               default: aluop = 3'd1;
            endcase
         end

         S_EXEC_R: begin
            instr_done = 1'b1;
            w_next     = S_FETCH;
            case (func)
               8'd1: begin
                  alusel = 2'd1;
                  aluop  = 3'd3;
                  reg_we = 1'b1;
               end
               8'd2: begin
                  aluop  = 3'd3;
                  reg_we = 1'b1;
               end
               8'd4: begin
                  aluop  = 3'd4;
                  reg_we = 1'b1;
               end
               8'd8: begin
                  aluop  = 3'd0;
                  reg_we = 1'b1;
               end
               8'd16: begin
                  aluop  = 3'd1;
                  reg_we = 1'b1;
               end
               8'd32: begin
                  aluop  = 3'd2;
                  reg_we = 1'b1;
               end
               default: reg_we = 1'b0;
            endcase
         end

         S_WND: begin
            changewnd  = 1'b1;
            instr_done = 1'b1;
            w_next     = S_FETCH;
         end

         S_ERR: err = 1'b1;

         default: w_next = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_multicycle_ctrlr.sv
// Directed bench for multicycle_ctrlr: the driver pushes hand-computed per-cycle output
// vectors into a queue; a negedge monitor pops and compares them against the DUT.
module tb_multicycle_ctrlr;

   localparam int TIMEOUT = 4;
   localparam int CNT_W   = 2;
   localparam int W       = 17 + CNT_W;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [3:0]       opcode = 4'd0;
   logic [7:0]       func = 8'd0;
   logic             zero = 1'b0;
   logic             mem_ready = 1'b0;
   logic             mem_req, mem_we, iord, ir_we, pc_we;
   logic [1:0]       pcsel, alusel;
   logic [2:0]       aluop;
   logic             datasel, reg_we, changewnd, instr_done, err;
   logic [CNT_W-1:0] instr_count;
   logic [3:0]       dbg_state;

   multicycle_ctrlr #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero(zero),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
      .ir_we(ir_we), .pc_we(pc_we), .pcsel(pcsel), .alusel(alusel), .aluop(aluop),
      .datasel(datasel), .reg_we(reg_we), .changewnd(changewnd),
      .instr_done(instr_done), .err(err), .instr_count(instr_count),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   logic [W-1:0]     exp_q[$];
   string            name_q[$];
   logic [CNT_W-1:0] exp_cnt = '0;
   int               checks = 0;
   int               errors = 0;

   // Field order: req we iord ir_we pc_we pcsel alusel aluop datasel reg_we changewnd done err count
   function automatic logic [W-1:0] mk(input int req, we, io, irw, pcw, ps, als, op,
                                       ds, rw, cw, dn, er);
      return {1'(req), 1'(we), 1'(io), 1'(irw), 1'(pcw), 2'(ps), 2'(als), 3'(op),
              1'(ds), 1'(rw), 1'(cw), 1'(dn), 1'(er), {CNT_W{1'b0}}};
   endfunction

   task automatic drive(input string nm, input int r, op, fn, z, rdy, input logic [W-1:0] e);
      @(posedge clk);
      #1;
      rst       = 1'(r);
      opcode    = 4'(op);
      func      = 8'(fn);
      zero      = 1'(z);
      mem_ready = 1'(rdy);
      if (r != 0) exp_cnt = '0;
      exp_q.push_back({e[W-1:CNT_W], exp_cnt});
      name_q.push_back(nm);
      if (e[CNT_W+1]) exp_cnt = exp_cnt + 1'b1;
   endtask

   always @(negedge clk) begin
      logic [W-1:0] exp_v;
      logic [W-1:0] act_v;
      string        nm;
      if (exp_q.size() > 0) begin
         exp_v = exp_q.pop_front();
         nm    = name_q.pop_front();
         act_v = {mem_req, mem_we, iord, ir_we, pc_we, pcsel, alusel, aluop,
                  datasel, reg_we, changewnd, instr_done, err, instr_count};
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", nm, act_v, exp_v, $time);
         end
      end
   end

   logic [W-1:0] n, fe_w, fe_r, rd_w, rd_r, wr_w, wr_r, brz1, brz0, jmp, wnd, nop, errv;
   int fn_t[8]  = '{1, 2, 4, 8, 16, 32, 64, 3};
   int als_t[8] = '{1, 0, 0, 0, 0, 0, 0, 0};
   int op_t[8]  = '{3, 3, 4, 0, 1, 2, 0, 0};
   int rw_t[8]  = '{1, 1, 1, 1, 1, 1, 0, 0};
   int iop_t[4] = '{3, 5, 0, 1};

   initial begin
      n    = mk(0,0,0,0,0,0,0,0,0,0,0,0,0);
      fe_w = mk(1,0,0,0,0,0,0,0,0,0,0,0,0);
      fe_r = mk(1,0,0,1,1,0,0,0,0,0,0,0,0);
      rd_w = mk(1,0,1,0,0,0,0,0,0,0,0,0,0);
      rd_r = mk(1,0,1,0,0,0,0,0,1,1,0,1,0);
      wr_w = mk(1,1,1,0,0,0,0,0,0,0,0,0,0);
      wr_r = mk(1,1,1,0,0,0,0,0,0,0,0,1,0);
      brz1 = mk(0,0,0,0,1,1,0,4,0,0,0,1,0);
      brz0 = mk(0,0,0,0,0,0,0,4,0,0,0,1,0);
      jmp  = mk(0,0,0,0,1,2,0,0,0,0,0,1,0);
      wnd  = mk(0,0,0,0,0,0,0,0,0,0,1,1,0);
      nop  = mk(0,0,0,0,0,0,0,0,0,0,0,1,0);
      errv = mk(0,0,0,0,0,0,0,0,0,0,0,0,1);

      // Reset: outputs stay 0 even with mem_ready high, then one IDLE cycle
      drive("rst0", 1, 4'b1100, 0, 0, 1, n);
      drive("rst1", 1, 4'b1100, 0, 0, 1, n);
      drive("idle", 0, 4'b1100, 0, 0, 0, n);

      // addi with two fetch waits
      drive("fetch_w1", 0, 4'b1100, 0, 0, 0, fe_w);
      drive("fetch_w2", 0, 4'b1100, 0, 0, 0, fe_w);
      drive("fetch_rdy", 0, 4'b1100, 0, 0, 1, fe_r);
      drive("dec_addi", 0, 4'b1100, 0, 0, 0, n);
      drive("exec_addi", 0, 4'b1100, 0, 0, 0, mk(0,0,0,0,0,0,2,3,0,1,0,1,0));

      // lw and sw with zero-wait memory
      drive("fetch_lw", 0, 4'b0000, 0, 0, 1, fe_r);
      drive("dec_lw", 0, 4'b0000, 0, 0, 0, n);
      drive("memrd_rdy", 0, 4'b0000, 0, 0, 1, rd_r);
      drive("fetch_sw", 0, 4'b0001, 0, 0, 1, fe_r);
      drive("dec_sw", 0, 4'b0001, 0, 0, 0, n);
      drive("memwr_rdy", 0, 4'b0001, 0, 0, 1, wr_r);

      // branchz taken (instr_count wraps 3 -> 0 here), not taken, then jump
      drive("fetch_brz1", 0, 4'b0100, 0, 1, 1, fe_r);
      drive("dec_brz1", 0, 4'b0100, 0, 1, 0, n);
      drive("brz_taken", 0, 4'b0100, 0, 1, 0, brz1);
      drive("fetch_brz0", 0, 4'b0100, 0, 0, 1, fe_r);
      drive("dec_brz0", 0, 4'b0100, 0, 0, 0, n);
      drive("brz_not", 0, 4'b0100, 0, 0, 0, brz0);
      drive("fetch_jmp", 0, 4'b0010, 0, 0, 1, fe_r);
      drive("dec_jmp", 0, 4'b0010, 0, 0, 0, n);
      drive("jump", 0, 4'b0010, 0, 0, 0, jmp);

      // Remaining immediate ops
      for (int i = 1; i < 4; i++) begin
         drive("fetch_imm", 0, 12 + i, 0, 0, 1, fe_r);
         drive("dec_imm", 0, 12 + i, 0, 0, 0, n);
         drive($sformatf("exec_imm_op%0d", 12 + i), 0, 12 + i, 0, 0, 0,
               mk(0,0,0,0,0,0,2,iop_t[i],0,1,0,1,0));
      end

      // rtype function table, including nop encodings 64 and 3
      for (int i = 0; i < 8; i++) begin
         drive("fetch_r", 0, 4'b1000, fn_t[i], 0, 1, fe_r);
         drive("dec_r", 0, 4'b1000, fn_t[i], 0, 0, n);
         drive($sformatf("exec_r_func%0d", fn_t[i]), 0, 4'b1000, fn_t[i], 0, 0,
               mk(0,0,0,0,0,0,als_t[i],op_t[i],0,rw_t[i],0,1,0));
      end

      // Window change pulses for exactly one cycle
      drive("fetch_wnd", 0, 4'b1000, 8'h80, 0, 1, fe_r);
      drive("dec_wnd", 0, 4'b1000, 8'h80, 0, 0, n);
      drive("wnd", 0, 4'b1000, 8'h80, 0, 0, wnd);

      // Undefined opcode retires straight out of DECODE
      drive("fetch_nop", 0, 4'b0011, 0, 0, 1, fe_r);
      drive("dec_nop", 0, 4'b0011, 0, 0, 0, nop);

      // lw whose ready arrives on the last allowed wait cycle
      drive("fetch_lw2", 0, 4'b0000, 0, 0, 1, fe_r);
      drive("dec_lw2", 0, 4'b0000, 0, 0, 0, n);
      for (int i = 0; i < TIMEOUT - 1; i++)
         drive("memrd_wait", 0, 4'b0000, 0, 0, 0, rd_w);
      drive("memrd_last_rdy", 0, 4'b0000, 0, 0, 1, rd_r);

      // Reset asserted during a MEM_WR wait
      drive("fetch_sw2", 0, 4'b0001, 0, 0, 1, fe_r);
      drive("dec_sw2", 0, 4'b0001, 0, 0, 0, n);
      drive("memwr_wait", 0, 4'b0001, 0, 0, 0, wr_w);
      drive("rst_mid_wr", 1, 4'b0001, 0, 0, 0, n);
      drive("idle2", 0, 4'b0001, 0, 0, 0, n);

      // Fetch timeout into sticky ERR
      for (int i = 0; i < TIMEOUT; i++)
         drive("fetch_to_wait", 0, 4'b0001, 0, 0, 0, fe_w);
      for (int i = 0; i < 3; i++)
         drive("err_sticky", 0, 4'b0001, 0, 0, 1, errv);

      // Reset recovers to IDLE then FETCH
      drive("rst_err", 1, 4'b0001, 0, 0, 1, n);
      drive("idle3", 0, 4'b0001, 0, 0, 1, n);
      drive("fetch_after_err", 0, 4'b0001, 0, 0, 1, fe_r);

      repeat (2) @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
